// File: rtl/mesi_txn_sequencer_if.sv
// Handshake, state-array, MESI next-state, bus and snoop signals of the transaction sequencer.
interface mesi_txn_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [7:0]        REQ_CMD;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic              ST_RD_EN;
    logic [ADDR_W-1:0] ST_RD_ADDR;
    logic [3:0]        ST_RD_DATA;
    logic              ST_WR_EN;
    logic [ADDR_W-1:0] ST_WR_ADDR;
    logic [3:0]        ST_WR_DATA;
    logic [7:0]        FSM_CMD;
    logic [3:0]        FSM_STATE;
    logic [1:0]        FSM_HM;
    logic [3:0]        FSM_NEXT;
    logic              BUS_VALID;
    logic              BUS_READY;
    logic [1:0]        BUS_OP;
    logic [ADDR_W-1:0] BUS_ADDR;
    logic              SNOOP_VALID;
    logic [1:0]        SNOOP_HM;
    logic              PUT_HM_VALID;
    logic [1:0]        PUT_HM;
    logic              DONE;
    logic [3:0]        DONE_STATE;
    logic              TIMEOUT;

    // Sequencer side: drives the state array, MESI logic inputs and bus requests.
    modport master (
        input  REQ_VALID, REQ_CMD, REQ_ADDR, ST_RD_DATA, FSM_NEXT, BUS_READY, SNOOP_VALID, SNOOP_HM,
        output REQ_READY, ST_RD_EN, ST_RD_ADDR, ST_WR_EN, ST_WR_ADDR, ST_WR_DATA,
               FSM_CMD, FSM_STATE, FSM_HM, BUS_VALID, BUS_OP, BUS_ADDR,
               PUT_HM_VALID, PUT_HM, DONE, DONE_STATE, TIMEOUT
    );

    // Environment side: requester, state array, MESI logic and front-side bus.
    modport slave (
        output REQ_VALID, REQ_CMD, REQ_ADDR, ST_RD_DATA, FSM_NEXT, BUS_READY, SNOOP_VALID, SNOOP_HM,
        input  REQ_READY, ST_RD_EN, ST_RD_ADDR, ST_WR_EN, ST_WR_ADDR, ST_WR_DATA,
               FSM_CMD, FSM_STATE, FSM_HM, BUS_VALID, BUS_OP, BUS_ADDR,
               PUT_HM_VALID, PUT_HM, DONE, DONE_STATE, TIMEOUT
    );
endinterface

// File: rtl/mesi_txn_sequencer.sv
// Runs one cache transaction at a time: state read, optional bus op + snoop wait, MESI update.
module mesi_txn_sequencer #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned SNOOP_TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RESET,
    mesi_txn_sequencer_if.master io
);
    localparam int unsigned CNT_W = $clog2(SNOOP_TIMEOUT + 1);

    localparam logic [3:0] ST_M = 4'b0001;
    localparam logic [3:0] ST_E = 4'b0010;
    localparam logic [3:0] ST_S = 4'b0100;
    localparam logic [3:0] ST_I = 4'b1000;

    localparam logic [1:0] HM_MISS = 2'd0;
    localparam logic [1:0] HM_HIT  = 2'd1;
    localparam logic [1:0] HM_HITM = 2'd2;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [1:0] OP_RWIM  = 2'd3;

    typedef enum logic [2:0] {IDLE, RD, EVAL, BUS_REQ, SNOOP_WAIT, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cur_q, cur_d;
    logic [1:0]        hm_q, hm_d;
    logic [1:0]        op_q, op_d;
    logic              snoop_q, snoop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        done_state_q, done_state_d;
    logic [3:0]        rd_cur;
    logic              fsm_live;

    // Anything that is not a clean one-hot state reads as INVALID.
    function automatic logic [3:0] sanitize(input logic [3:0] s);
        case (s)
            ST_M, ST_E, ST_S, ST_I: return s;
            default:                return ST_I;
        endcase
    endfunction

    // MESI next-state inputs are live from EVAL through UPDATE; EVAL forwards the fresh read.
    assign rd_cur        = sanitize(io.ST_RD_DATA);
    assign fsm_live      = state_q inside {EVAL, BUS_REQ, SNOOP_WAIT, UPDATE};
    assign io.FSM_CMD    = fsm_live ? cmd_q : 8'd0;
    assign io.FSM_STATE  = (state_q == EVAL) ? rd_cur : (fsm_live ? cur_q : 4'd0);
    assign io.FSM_HM     = fsm_live ? hm_q : 2'd0;
    assign io.DONE_STATE = done_state_d;

    // State and transaction latches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cmd_q        <= 8'd0;
            addr_q       <= '0;
            cur_q        <= ST_I;
            hm_q         <= HM_MISS;
            op_q         <= OP_READ;
            snoop_q      <= 1'b0;
            cnt_q        <= '0;
            done_state_q <= ST_I;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            cur_q        <= cur_d;
            hm_q         <= hm_d;
            op_q         <= op_d;
            snoop_q      <= snoop_d;
            cnt_q        <= cnt_d;
            done_state_q <= done_state_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        addr_d          = addr_q;
        cur_d           = cur_q;
        hm_d            = hm_q;
        op_d            = op_q;
        snoop_d         = snoop_q;
        cnt_d           = cnt_q;
        done_state_d    = done_state_q;
        io.REQ_READY    = 1'b0;
        io.ST_RD_EN     = 1'b0;
        io.ST_RD_ADDR   = '0;
        io.ST_WR_EN     = 1'b0;
        io.ST_WR_ADDR   = '0;
        io.ST_WR_DATA   = 4'd0;
        io.BUS_VALID    = 1'b0;
        io.BUS_OP       = 2'd0;
        io.BUS_ADDR     = '0;
        io.PUT_HM_VALID = 1'b0;
        io.PUT_HM       = 2'd0;
        io.DONE         = 1'b0;
        io.TIMEOUT      = 1'b0;

        case (state_q)
            IDLE: begin
                io.REQ_READY = 1'b1;
                if (io.REQ_VALID) begin
                    cmd_d   = io.REQ_CMD;
                    addr_d  = io.REQ_ADDR;
                    hm_d    = HM_MISS;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                io.ST_RD_EN   = 1'b1;
                io.ST_RD_ADDR = addr_q;
                state_d       = EVAL;
            end
            EVAL: begin
                cur_d   = rd_cur;
                snoop_d = 1'b0;
                state_d = UPDATE;
                if (cmd_q inside {8'd3, 8'd4, 8'd5, 8'd6}) begin
                    io.PUT_HM_VALID = 1'b1;
                    io.PUT_HM = (rd_cur == ST_M) ? HM_HITM : ((rd_cur == ST_I) ? HM_MISS : HM_HIT);
                end
                case (cmd_q)
                    8'd0, 8'd2: if (rd_cur == ST_I) begin
                        op_d = OP_READ; snoop_d = 1'b1; state_d = BUS_REQ;
                    end
                    8'd1: if (rd_cur == ST_I) begin
                        op_d = OP_RWIM; snoop_d = 1'b1; state_d = BUS_REQ;
                    end else if (rd_cur == ST_S) begin
                        op_d = OP_INVAL; state_d = BUS_REQ;
                    end
                    8'd4, 8'd6: if (rd_cur == ST_M) begin
                        op_d = OP_WRITE; state_d = BUS_REQ;
                    end
                    default: ;
                endcase
            end
            BUS_REQ: begin
                io.BUS_VALID = 1'b1;
                io.BUS_OP    = op_q;
                io.BUS_ADDR  = addr_q;
                if (io.BUS_READY) begin
                    cnt_d   = '0;
                    state_d = snoop_q ? SNOOP_WAIT : UPDATE;
                end
            end
            SNOOP_WAIT: begin
                if (io.SNOOP_VALID) begin
                    hm_d    = (io.SNOOP_HM == 2'd3) ? HM_HITM : io.SNOOP_HM;
                    state_d = UPDATE;
                end else if (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                    hm_d       = HM_MISS;
                    io.TIMEOUT = 1'b1;
                    state_d    = UPDATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UPDATE: begin
                io.DONE = 1'b1;
                if (cmd_q <= 8'd6) begin
                    io.ST_WR_EN   = 1'b1;
                    io.ST_WR_ADDR = addr_q;
                    io.ST_WR_DATA = io.FSM_NEXT;
                    done_state_d  = io.FSM_NEXT;
                end else begin
                    done_state_d  = cur_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mesi_txn_sequencer.sv
// Randomized self-checking bench for mesi_txn_sequencer with a transaction-level reference model.
module tb_mesi_txn_sequencer;
    localparam int unsigned ADDR_W  = 32;
    localparam int          TO      = 15;
    localparam int          MAX_CYC = 80;

    localparam logic [3:0] S_M = 4'b0001;
    localparam logic [3:0] S_E = 4'b0010;
    localparam logic [3:0] S_S = 4'b0100;
    localparam logic [3:0] S_I = 4'b1000;

    logic CLK = 1'b0;
    logic RESET;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [3:0] mem [16];
    logic [3:0] ref_mem [16];
    logic [3:0] rd_q;
    logic       seed_en;
    logic [3:0] seed_idx;
    logic [3:0] seed_val;
    logic [3:0] last_ds;

    mesi_txn_sequencer_if #(.ADDR_W(ADDR_W)) io ();

    mesi_txn_sequencer #(.ADDR_W(ADDR_W), .SNOOP_TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .io    (io)
    );

    always #5 CLK = ~CLK;

    // Reference MESI next-state table used both as the external block and as the expectation.
    function automatic logic [3:0] mesi_next(input logic [7:0] cmd, input logic [3:0] st, input logic [1:0] hm);
        if (!(st inside {S_M, S_E, S_S, S_I})) return S_I;
        case (cmd)
            8'd0, 8'd2: return (st == S_I) ? ((hm == 2'd0) ? S_E : S_S) : st;
            8'd1:       return S_M;
            8'd3, 8'd6: return S_I;
            8'd4:       return (st == S_I) ? S_I : S_S;
            default:    return st;
        endcase
    endfunction

    assign io.FSM_NEXT   = mesi_next(io.FSM_CMD, io.FSM_STATE, io.FSM_HM);
    assign io.ST_RD_DATA = rd_q;

    // State array: one-cycle read latency, junk on the read port when not reading.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) mem[i] <= S_I;
            rd_q <= 4'($urandom);
        end else begin
            rd_q <= io.ST_RD_EN ? mem[io.ST_RD_ADDR[3:0]] : 4'($urandom);
            if (seed_en) mem[seed_idx] <= seed_val;
            if (io.ST_WR_EN) mem[io.ST_WR_ADDR[3:0]] <= io.ST_WR_DATA;
        end
    end

    task automatic run_txn(input string name, input logic [7:0] cmd, input logic [3:0] idx, input bit seed,
                           input logic [3:0] seed_v, input int bus_dly, input int snp_dly, input logic [1:0] snp_hm);
        logic [ADDR_W-1:0] addr, bus_addr_s, rd_addr_s, wr_addr_s;
        logic [3:0] raw, cur, exp_next, exp_ds, wr_d, ds_s, fst_s, ds_hold;
        logic [1:0] exp_hm, exp_op, exp_put, put_v, bus_op_s, fhm_s;
        logic [7:0] fcmd_s;
        bit exp_bus, exp_snp, exp_to, exp_put_v, exp_wr, in_time, bus_unstable, ready0;
        int exp_done, exp_to_c, done_c, bus_first, bus_cyc, bus_acc;
        int rd_cnt, rd_c, put_cnt, put_c, wr_cnt, wr_c, to_cnt, to_c, ready_busy;

        addr = ADDR_W'({28'($urandom), idx});
        raw  = seed ? seed_v : ref_mem[idx];
        cur  = $onehot(raw) ? raw : S_I;
        exp_bus = 0; exp_snp = 0; exp_op = 2'd0;
        if ((cmd == 8'd0 || cmd == 8'd2) && cur == S_I) begin exp_bus = 1; exp_snp = 1; exp_op = 2'd0; end
        else if (cmd == 8'd1 && cur == S_I) begin exp_bus = 1; exp_snp = 1; exp_op = 2'd3; end
        else if (cmd == 8'd1 && cur == S_S) begin exp_bus = 1; exp_op = 2'd2; end
        else if ((cmd == 8'd4 || cmd == 8'd6) && cur == S_M) begin exp_bus = 1; exp_op = 2'd1; end
        in_time   = snp_dly >= 0 && snp_dly < TO;
        exp_to    = exp_snp && !in_time;
        exp_hm    = (exp_snp && in_time) ? ((snp_hm == 2'd3) ? 2'd2 : snp_hm) : 2'd0;
        exp_done  = 3 + (exp_bus ? bus_dly + 1 : 0) + (exp_snp ? (in_time ? snp_dly + 1 : TO) : 0);
        exp_to_c  = 4 + bus_dly + TO - 1;
        exp_put_v = cmd >= 8'd3 && cmd <= 8'd6;
        exp_put   = (cur == S_M) ? 2'd2 : ((cur == S_I) ? 2'd0 : 2'd1);
        exp_wr    = cmd <= 8'd6;
        exp_next  = mesi_next(cmd, cur, exp_hm);
        exp_ds    = exp_wr ? exp_next : cur;

        done_c = -1; bus_first = -1; bus_cyc = 0; bus_acc = -1; bus_unstable = 0; ready0 = 0;
        rd_cnt = 0; rd_c = -1; put_cnt = 0; put_c = -1; wr_cnt = 0; wr_c = -1; to_cnt = 0; to_c = -1; ready_busy = 0;
        put_v = 0; bus_op_s = 0; bus_addr_s = 0; rd_addr_s = 0; wr_addr_s = 0; wr_d = 0; ds_s = 0; fst_s = 0;
        fhm_s = 0; fcmd_s = 0; ds_hold = 0;

        for (int c = 0; c < MAX_CYC && done_c < 0; c++) begin
            @(negedge CLK);
            io.REQ_VALID   = (c == 0) ? 1'b1 : 1'($urandom);
            io.REQ_CMD     = (c == 0) ? cmd : 8'($urandom);
            io.REQ_ADDR    = (c == 0) ? addr : ADDR_W'($urandom);
            io.BUS_READY   = 1'b0;
            io.SNOOP_VALID = 1'b0;
            io.SNOOP_HM    = 2'($urandom);
            seed_en = (c == 0) && seed; seed_idx = idx; seed_val = seed_v;
            #1;
            if (io.BUS_VALID) begin
                bus_cyc++;
                if (bus_first < 0) begin bus_first = c; bus_op_s = io.BUS_OP; bus_addr_s = io.BUS_ADDR; end
                else if (io.BUS_OP !== bus_op_s || io.BUS_ADDR !== bus_addr_s) bus_unstable = 1;
                if (bus_acc < 0 && c - bus_first >= bus_dly) begin io.BUS_READY = 1'b1; bus_acc = c; end
            end else if ($urandom_range(3) == 0) io.BUS_READY = 1'b1;
            if (bus_acc >= 0 && snp_dly >= 0 && c == bus_acc + 1 + snp_dly) begin
                io.SNOOP_VALID = 1'b1; io.SNOOP_HM = snp_hm;
            end else if (bus_acc < 0 && $urandom_range(2) == 0) io.SNOOP_VALID = 1'b1;
            #1;
            if (c == 0) begin ready0 = io.REQ_READY; ds_hold = io.DONE_STATE; end
            else if (io.REQ_READY) ready_busy++;
            if (io.ST_RD_EN) begin rd_cnt++; rd_c = c; rd_addr_s = io.ST_RD_ADDR; end
            if (io.PUT_HM_VALID) begin put_cnt++; put_c = c; put_v = io.PUT_HM; end
            if (io.TIMEOUT) begin to_cnt++; to_c = c; end
            if (io.ST_WR_EN) begin wr_cnt++; wr_c = c; wr_addr_s = io.ST_WR_ADDR; wr_d = io.ST_WR_DATA; end
            if (io.DONE) begin
                done_c = c; ds_s = io.DONE_STATE;
                fcmd_s = io.FSM_CMD; fst_s = io.FSM_STATE; fhm_s = io.FSM_HM;
            end
        end
        seed_en = 1'b0;

        n_assert++; if (done_c != exp_done) begin n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_c, exp_done); end
        n_assert++; if (ready0 !== 1'b1 || ready_busy != 0) begin n_fail++; $display("FAIL %s req_ready: accept=%b busy_cycles=%0d expected 1/0", name, ready0, ready_busy); end
        n_assert++; if (ds_hold !== last_ds) begin n_fail++; $display("FAIL %s done_state_hold: got %b expected %b", name, ds_hold, last_ds); end
        n_assert++; if (rd_cnt != 1 || rd_c != 1 || rd_addr_s !== addr) begin n_fail++; $display("FAIL %s state_read: count=%0d cycle=%0d addr=%h expected 1/1/%h", name, rd_cnt, rd_c, rd_addr_s, addr); end
        n_assert++; if (put_cnt != int'(exp_put_v) || (exp_put_v && (put_c != 2 || put_v !== exp_put))) begin n_fail++; $display("FAIL %s put_hm: count=%0d cycle=%0d val=%0d expected %0d/2/%0d", name, put_cnt, put_c, put_v, exp_put_v, exp_put); end
        n_assert++; if ((bus_first >= 0) != exp_bus || (exp_bus && (bus_first != 3 || bus_op_s !== exp_op || bus_addr_s !== addr || bus_unstable || bus_cyc != bus_dly + 1))) begin n_fail++; $display("FAIL %s bus_op: first=%0d op=%0d addr=%h cycles=%0d unstable=%b expected bus=%b op=%0d addr=%h cycles=%0d", name, bus_first, bus_op_s, bus_addr_s, bus_cyc, bus_unstable, exp_bus, exp_op, addr, bus_dly + 1); end
        n_assert++; if (to_cnt != int'(exp_to) || (exp_to && to_c != exp_to_c)) begin n_fail++; $display("FAIL %s timeout: count=%0d cycle=%0d expected %0d/%0d", name, to_cnt, to_c, exp_to, exp_to_c); end
        n_assert++; if (fcmd_s !== cmd || fst_s !== cur || fhm_s !== exp_hm) begin n_fail++; $display("FAIL %s fsm_inputs: cmd=%0d state=%b hm=%0d expected %0d/%b/%0d", name, fcmd_s, fst_s, fhm_s, cmd, cur, exp_hm); end
        n_assert++; if (wr_cnt != int'(exp_wr) || (exp_wr && (wr_c != done_c || wr_d !== exp_next || wr_addr_s !== addr))) begin n_fail++; $display("FAIL %s state_write: count=%0d cycle=%0d data=%b addr=%h expected %0d/%0d/%b/%h", name, wr_cnt, wr_c, wr_d, wr_addr_s, exp_wr, done_c, exp_next, addr); end
        n_assert++; if (ds_s !== exp_ds) begin n_fail++; $display("FAIL %s done_state: got %b expected %b", name, ds_s, exp_ds); end

        ref_mem[idx] = exp_wr ? exp_next : raw;
        last_ds = exp_ds;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = S_I;
        last_ds = S_I;
        #1;
        n_assert++; if (io.REQ_READY !== 1'b1 || io.DONE_STATE !== S_I) begin n_fail++; $display("FAIL reset_ready_state: ready=%b done_state=%b expected 1/1000", io.REQ_READY, io.DONE_STATE); end
        n_assert++; if ({io.ST_RD_EN, io.ST_WR_EN, io.BUS_VALID, io.DONE, io.PUT_HM_VALID, io.TIMEOUT} !== 6'd0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000000", {io.ST_RD_EN, io.ST_WR_EN, io.BUS_VALID, io.DONE, io.PUT_HM_VALID, io.TIMEOUT}); end
        n_assert++; if ({io.FSM_CMD, io.FSM_STATE, io.FSM_HM, io.BUS_OP, io.PUT_HM, io.ST_WR_DATA} !== 22'd0) begin n_fail++; $display("FAIL reset_buses: got %h expected 0", {io.FSM_CMD, io.FSM_STATE, io.FSM_HM, io.BUS_OP, io.PUT_HM, io.ST_WR_DATA}); end
    endtask

    task automatic test_read_miss();
        run_txn("read_miss", 8'd0, 4'd1, 1'b1, S_I, 0, 1, 2'd0);
    endtask

    task automatic test_write_shared();
        run_txn("write_shared", 8'd1, 4'd2, 1'b1, S_S, 0, 0, 2'd0);
    endtask

    task automatic test_snoop_read_modified();
        run_txn("snoop_read_m", 8'd4, 4'd3, 1'b1, S_M, 0, 0, 2'd0);
    endtask

    task automatic test_snoop_timeout();
        run_txn("ifetch_timeout", 8'd2, 4'd4, 1'b1, S_I, 1, -1, 2'd0);
        run_txn("snoop_at_limit", 8'd0, 4'd6, 1'b1, S_I, 0, TO - 1, 2'd1);
        run_txn("snoop_past_limit", 8'd1, 4'd7, 1'b1, S_I, 2, TO, 2'd2);
        run_txn("snoop_hm3", 8'd0, 4'd8, 1'b1, S_I, 0, 3, 2'd3);
    endtask

    task automatic test_hit_and_noop();
        run_txn("read_hit", 8'd0, 4'd5, 1'b1, S_E, 0, 0, 2'd0);
        run_txn("noop_cmd9", 8'd9, 4'd5, 1'b0, S_I, 0, 0, 2'd0);
        run_txn("non_onehot", 8'd3, 4'd9, 1'b1, 4'b0110, 0, 0, 2'd0);
    endtask

    task automatic test_reset_mid_txn();
        int bad;
        bad = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge CLK);
            io.REQ_VALID   = (c == 0);
            io.REQ_CMD     = 8'd0;
            io.REQ_ADDR    = ADDR_W'(32'h0000_0A0A);
            io.BUS_READY   = 1'b1;
            io.SNOOP_VALID = (c == 7);
            io.SNOOP_HM    = 2'd1;
            RESET          = (c == 6);
            #1;
            if (c == 7) begin
                n_assert++; if (io.REQ_READY !== 1'b1 || io.DONE_STATE !== S_I) begin n_fail++; $display("FAIL reset_mid_txn_state: ready=%b done_state=%b expected 1/1000", io.REQ_READY, io.DONE_STATE); end
            end
            if (c >= 7 && (io.ST_WR_EN || io.DONE || io.BUS_VALID)) bad++;
        end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL reset_mid_txn_quiet: strobe cycles=%0d expected 0", bad); end
        for (int i = 0; i < 16; i++) ref_mem[i] = S_I;
        last_ds = S_I;
        run_txn("after_reset", 8'd0, 4'd10, 1'b0, S_I, 1, 2, 2'd1);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_read", 8'd0, 4'd11, 1'b1, S_I, 0, 0, 2'd0);
        run_txn("b2b_write_e", 8'd1, 4'd11, 1'b0, S_I, 0, 0, 2'd0);
        run_txn("b2b_snoop_rwim", 8'd6, 4'd11, 1'b0, S_I, 1, 0, 2'd0);
        run_txn("b2b_write_i", 8'd1, 4'd11, 1'b0, S_I, 0, 2, 2'd2);
        run_txn("b2b_inval", 8'd3, 4'd11, 1'b0, S_I, 0, 0, 2'd0);
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        int snp;
        for (int n = 0; n < 60; n++) begin
            cmd = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(9));
            snp = $urandom_range(TO + 2);
            run_txn("random", cmd, 4'($urandom), $urandom_range(2) == 0, 4'($urandom),
                    $urandom_range(3), (snp == TO + 2) ? -1 : snp, 2'($urandom));
        end
    endtask

    initial begin
        RESET = 1'b1;
        io.REQ_VALID = 1'b0; io.REQ_CMD = 8'd0; io.REQ_ADDR = '0;
        io.BUS_READY = 1'b0; io.SNOOP_VALID = 1'b0; io.SNOOP_HM = 2'd0;
        seed_en = 1'b0; seed_idx = 4'd0; seed_val = S_I; last_ds = S_I;
        test_reset();
        test_read_miss();
        test_write_shared();
        test_snoop_read_modified();
        test_snoop_timeout();
        test_hit_and_noop();
        test_reset_mid_txn();
        test_back_to_back();
        test_random();
        @(negedge CLK);
        io.REQ_VALID = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mesi_txn_sequencer.md
Name: mesi_txn_sequencer

Overview:
- Sequences one cache transaction at a time through the per-line MESI next-state logic. The MESI next-state logic is a combinational function of command, current state and hit/miss.
- The sequencer accepts a trace command and address, then reads the line's current state from the state array.
- When the command needs it, it issues an FSB bus operation and collects the snoop result, then drives command/state/hit-miss into the MESI next-state logic.
- It writes the returned next state back to the state array and reports snoop replies and completion. It sits directly upstream of the MESI next-state logic and owns all of its inputs.

Parameters:
ADDR_W, 32, request/bus/state-array address width
SNOOP_TIMEOUT, 15, maximum cycles waited in SNOOP_WAIT before forcing a MISS result (must be >= 1)

Ports:
CLK  in  1  single clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  sequencer idle; request accepted when REQ_VALID && REQ_READY
REQ_CMD  in  8  trace command: 0 L1 data read, 1 L1 write, 2 L1 instr read, 3 snooped invalidate, 4 snooped read, 5 snooped write, 6 snooped RWIM, >=7 no-op
REQ_ADDR  in  ADDR_W  line address
ST_RD_EN  out  1  state-array read strobe
ST_RD_ADDR  out  ADDR_W  state-array read address
ST_RD_DATA  in  4  one-hot MESI state (M=0001, E=0010, S=0100, I=1000); valid the cycle after ST_RD_EN
ST_WR_EN  out  1  state-array write strobe
ST_WR_ADDR  out  ADDR_W  state-array write address
ST_WR_DATA  out  4  next state to write
FSM_CMD  out  8  to MESI next-state logic
FSM_STATE  out  4  to MESI next-state logic
FSM_HM  out  2  to MESI next-state logic: 0 MISS, 1 HIT, 2 HITM
FSM_NEXT  in  4  from MESI next-state logic (combinational)
BUS_VALID  out  1  bus operation request
BUS_READY  in  1  bus accepts operation
BUS_OP  out  2  0 READ, 1 WRITE (writeback), 2 INVALIDATE, 3 RWIM
BUS_ADDR  out  ADDR_W  bus operation address
SNOOP_VALID  in  1  snoop result valid
SNOOP_HM  in  2  snoop result: 0 MISS, 1 HIT, 2 HITM
PUT_HM_VALID  out  1  one-cycle pulse: our snoop reply is valid
PUT_HM  out  2  our snoop reply: 0 NOHIT, 1 HIT, 2 HITM
DONE  out  1  one-cycle pulse: transaction complete
DONE_STATE  out  4  final state of the line; held until the next DONE
TIMEOUT  out  1  one-cycle pulse when the snoop wait expires

Behaviour:
- Reset: go to state IDLE. All outputs 0, except REQ_READY=1 and DONE_STATE=1000 (INVALID). Internal counters and latches cleared.
- Reset mid-transaction aborts the transaction: no ST_WR_EN, DONE or BUS_VALID in the following cycle.
- State machine states: IDLE, RD, EVAL, BUS_REQ, SNOOP_WAIT, UPDATE.
- IDLE: REQ_READY=1. On accept, latch cmd/addr and go to RD. REQ_READY=0 in every other state.
- RD: ST_RD_EN=1 for exactly one cycle, ST_RD_ADDR=latched addr. Go to EVAL.
- EVAL: capture ST_RD_DATA as cur. A non-one-hot value is treated as INVALID (1000).
- EVAL, snoop reply for cmd 3..6: PUT_HM_VALID=1 this cycle. PUT_HM = 2 if cur=M, 1 if cur=E or S, 0 if cur=I.
- EVAL, bus decision:
  - cmd 0/2 with cur=I: BUS READ, wait for snoop.
  - cmd 1 with cur=I: BUS RWIM, wait for snoop.
  - cmd 1 with cur=S: BUS INVALIDATE, no wait.
  - cmd 4/6 with cur=M: BUS WRITE, no wait.
  - Any other combination: no bus operation; go straight to UPDATE.
- EVAL, cmd >= 7: go to UPDATE, but suppress ST_WR_EN.
- BUS_REQ: BUS_VALID=1 with BUS_OP and BUS_ADDR stable until the cycle BUS_READY=1. Then go to SNOOP_WAIT (READ/RWIM) or UPDATE (others).
- SNOOP_WAIT: counter starts at 0 and increments each cycle.
  - On SNOOP_VALID: capture hm=SNOOP_HM; go to UPDATE.
  - If the counter reaches SNOOP_TIMEOUT without SNOOP_VALID: hm=0, TIMEOUT pulse, go to UPDATE.
  - SNOOP_VALID arriving in the same cycle as the counter reaching SNOOP_TIMEOUT wins: no TIMEOUT pulse.
  - SNOOP_VALID outside SNOOP_WAIT is ignored.
- hm = 0 when no snoop wait occurred. SNOOP_HM = 3 is treated as HITM.
- FSM_CMD, FSM_STATE and FSM_HM are driven from latched cmd/cur/hm from EVAL through UPDATE. They are 0 otherwise.
- UPDATE, single cycle:
  - ST_WR_EN=1 with ST_WR_ADDR=addr and ST_WR_DATA=FSM_NEXT; suppressed for cmd >= 7.
  - DONE=1. DONE_STATE = FSM_NEXT, or cur when the write is suppressed.
  - Then go to IDLE.
- Latency with no bus operation: accept in cycle T, ST_RD_EN in T+1, EVAL in T+2, ST_WR_EN/DONE in T+3, REQ_READY again in T+4.
- Latency with a bus operation: 3 cycles plus bus wait plus snoop wait.
- Exactly one ST_WR_EN per completed transaction with cmd <= 6.

Test Plan:
- cmd 0, cur=I, BUS_READY same cycle, SNOOP_VALID with HM=0 two cycles later -> BUS_OP=0; ST_WR_DATA=0010; DONE_STATE=0010.
- cmd 1, cur=S -> BUS_OP=2 with no snoop wait; ST_WR_DATA=0001; DONE 4 cycles after accept when BUS_READY is immediate.
- cmd 4, cur=M -> PUT_HM_VALID with PUT_HM=2 at T+2; BUS_OP=1 writeback; ST_WR_DATA=0100.
- cmd 2, cur=I, SNOOP_VALID never asserted, SNOOP_TIMEOUT=15 -> TIMEOUT pulse after 15 SNOOP_WAIT cycles; FSM_HM=0; ST_WR_DATA=0010.
- cmd 0, cur=E (hit) -> no BUS_VALID; ST_WR_EN at T+3 with 0010; cmd 9 -> DONE with no ST_WR_EN.
- RESET asserted while in SNOOP_WAIT -> next cycle REQ_READY=1 and DONE_STATE=1000; no ST_WR_EN or DONE afterwards; a fresh request completes normally.
